bpred_resolve_ctrl: RTL and testbench
=====================================

Name: bpred_resolve_ctrl

Overview:
- Sequences the 2-bit branch predictor against the execute stage.
- Queues every predicted branch issued from IF in program order. Compares each one with its EX resolution, then drives the predictor update strobes (branch_flag / branch_taken_flag).
- On a misprediction it issues the pipeline flush and PC redirect, and discards wrong-path branches.
- Sits between IF, EX and two_bit_bpredictor.

Parameters:
- DEPTH, 4, max in-flight predicted branches (power of 2, ≥2)
- PC_W, 32, PC width
- FLUSH_CYCLES, 2, cycles flush is held after a mispredict (≥1)
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- pred_valid  in  1  IF issues a predicted branch this cycle
- pred_taken  in  1  predicted direction
- pred_target  in  PC_W  predicted taken target
- pred_fallthru  in  PC_W  branch PC+4
- pred_ready  out  1  push accepted when pred_valid&&pred_ready
- res_valid  in  1  EX resolves the oldest in-flight branch
- res_taken  in  1  actual direction
- res_target  in  PC_W  actual taken target
- upd_valid  out  1  predictor update strobe (to branch_flag)
- upd_taken  out  1  actual outcome (to branch_taken_flag)
- flush  out  1  kill IF/ID wrong-path instructions
- redirect_valid  out  1  one-cycle PC redirect pulse
- redirect_pc  out  PC_W  corrected fetch PC
- inflight  out  $clog2(DEPTH+1)  queued branch count
- branch_cnt  out  CNT_W  resolved branches, saturating
- mispred_cnt  out  CNT_W  mispredictions, saturating
- res_err  out  1  sticky: resolve arrived with queue empty

Behaviour:
- Reset (rst=0, async):
  - Queue empty; rd/wr pointers = 0; state RUN.
  - All outputs 0 except pred_ready=1.
  - Counters 0; res_err 0.
- Queue entry: {pred_taken, pred_target, pred_fallthru}. Circular FIFO with pointer wrap at DEPTH.
- pred_ready = (state==RUN) && (inflight<DEPTH), from registered state only.
- Simultaneous push and pop in one cycle is allowed; inflight is then unchanged.
- Resolution at cycle N with queue non-empty: compare the head entry.
  - Mispredict = (res_taken != pred_taken) || (res_taken && res_target != pred_target).
- Outputs registered, valid at cycle N+1:
  - upd_valid=1 and upd_taken=res_taken for exactly 1 cycle.
  - branch_cnt +1, saturating at all-ones.
- On correct prediction: head popped; no flush.
- On mispredict:
  - At N+1: redirect_valid=1 for 1 cycle; redirect_pc = res_taken ? res_target : head.pred_fallthru; mispred_cnt +1, saturating.
  - Entire queue cleared, including any push accepted in cycle N. inflight=0 at N+1.
  - State goes to FLUSH. flush=1 for cycles N+1..N+FLUSH_CYCLES; pred_ready=0 over the same cycles.
  - Return to RUN after the count; pred_ready=1 at N+FLUSH_CYCLES+1.
- pred_valid while pred_ready=0 is ignored; no state change.
- res_valid with queue empty, including during FLUSH:
  - No pop, no upd_valid, counters unchanged.
  - res_err set and held until reset.
- States:
  - RUN→FLUSH on mispredict.
  - FLUSH→RUN when the internal flush counter reaches FLUSH_CYCLES.
  - A mispredict cannot occur in FLUSH, because the queue is empty.
- Reset asserted mid-flush or mid-queue: everything returns immediately to reset values; no redirect pulse is emitted.

Test Plan:
- Reset, then push 4 branches (pred_taken=1, targets 0x100..0x130). Expect pred_ready=0 after the 4th and inflight=4. A 5th pred_valid is ignored, inflight stays 4.
- Resolve all 4 taken with matching targets, one per cycle. Expect upd_valid 4 consecutive cycles with upd_taken=1, flush never high, branch_cnt=4, mispred_cnt=0, inflight=0.
- Push pred_taken=1, target 0x200, fallthru 0x44; resolve res_taken=0. At N+1 expect redirect_valid=1, redirect_pc=0x44, upd_taken=0, flush high 2 cycles, pred_ready low 2 cycles, mispred_cnt=1.
- Push 3 branches; resolve the first taken with res_target=0x300 vs pred 0x280, while pushing a 4th in the same cycle. Expect redirect_pc=0x300 and inflight=0 at N+1 (all 4 discarded).
- With DEPTH=4: push/pop concurrently for 10 cycles, crossing pointer wrap. Expect FIFO order preserved and upd_taken matching res_taken each cycle.
- Resolve with empty queue → res_err=1, no upd_valid. Then force branch_cnt to all-ones and resolve: branch_cnt holds at 0xFFFF. Deassert rst mid-flush: flush=0 and pred_ready=1 immediately.

Source files
------------

// File: rtl/bpred_resolve_ctrl.sv
// Branch resolve controller: queues predicted branches from IF, checks them against EX
// resolutions in order, drives predictor updates, and flushes/redirects on mispredict.
module bpred_resolve_ctrl #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pred_valid,
  input  logic                         pred_taken,
  input  logic [PC_W-1:0]              pred_target,
  input  logic [PC_W-1:0]              pred_fallthru,
  output logic                         pred_ready,
  input  logic                         res_valid,
  input  logic                         res_taken,
  input  logic [PC_W-1:0]              res_target,
  output logic                         upd_valid,
  output logic                         upd_taken,
  output logic                         flush,
  output logic                         redirect_valid,
  output logic [PC_W-1:0]              redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]   inflight,
  output logic [CNT_W-1:0]             branch_cnt,
  output logic [CNT_W-1:0]             mispred_cnt,
  output logic                         res_err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam int unsigned FcW  = $clog2(FLUSH_CYCLES + 1);
  localparam logic [OccW-1:0] FullOcc  = OccW'(DEPTH);
  localparam logic [FcW-1:0]  FlushEnd = FcW'(FLUSH_CYCLES);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [FcW-1:0]    fcnt_q, fcnt_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [OccW-1:0]   occ_q, occ_d;
  logic [DEPTH-1:0]  taken_q;
  logic [PC_W-1:0]   target_q   [DEPTH];
  logic [PC_W-1:0]   fallthru_q [DEPTH];

  logic              upd_valid_q, upd_valid_d;
  logic              upd_taken_q, upd_taken_d;
  logic              redir_valid_q, redir_valid_d;
  logic [PC_W-1:0]   redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;
  logic              res_err_q, res_err_d;

  logic              ready;
  logic              push;
  logic              res_hit;
  logic              mispred;
  logic              head_taken;
  logic [PC_W-1:0]   head_target;
  logic [PC_W-1:0]   head_fallthru;

  assign ready         = (state_q == StRun) && (occ_q < FullOcc);
  assign push          = pred_valid && ready;
  assign res_hit       = res_valid && (occ_q != '0);
  assign head_taken    = taken_q[rd_ptr_q];
  assign head_target   = target_q[rd_ptr_q];
  assign head_fallthru = fallthru_q[rd_ptr_q];
  assign mispred       = res_hit &&
                         ((res_taken != head_taken) || (res_taken && (res_target != head_target)));

  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    occ_d         = occ_q;
    upd_valid_d   = 1'b0;
    upd_taken_d   = 1'b0;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    res_err_d     = res_err_q | (res_valid && (occ_q == '0));

    if (res_hit) begin
      upd_valid_d = 1'b1;
      upd_taken_d = res_taken;
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + 1'b1;
    end

    if (mispred) begin
      // Wrong path: drop everything, including a push accepted this same cycle.
      redir_valid_d = 1'b1;
      redir_pc_d    = res_taken ? res_target : head_fallthru;
      if (mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + 1'b1;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push)    wr_ptr_d = wr_ptr_q + 1'b1;
      if (res_hit) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, res_hit})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end

    unique case (state_q)
      StRun: begin
        if (mispred) begin
          state_d = StFlush;
          fcnt_d  = FcW'(1);
        end
      end
      StFlush: begin
        if (fcnt_q == FlushEnd) begin
          state_d = StRun;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StRun;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StRun;
      fcnt_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      occ_q         <= '0;
      upd_valid_q   <= 1'b0;
      upd_taken_q   <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
      res_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      occ_q         <= occ_d;
      upd_valid_q   <= upd_valid_d;
      upd_taken_q   <= upd_taken_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      res_err_q     <= res_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        target_q[i]   <= '0;
        fallthru_q[i] <= '0;
      end
    end else if (push && !mispred) begin
      taken_q[wr_ptr_q]    <= pred_taken;
      target_q[wr_ptr_q]   <= pred_target;
      fallthru_q[wr_ptr_q] <= pred_fallthru;
    end
  end

  assign pred_ready     = ready;
  assign upd_valid      = upd_valid_q;
  assign upd_taken      = upd_taken_q;
  assign flush          = (state_q == StFlush);
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign inflight       = occ_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;
  assign res_err        = res_err_q;

endmodule

// File: tb/tb_bpred_resolve_ctrl.sv
// Directed self-checking bench for bpred_resolve_ctrl; a second small instance covers saturation.
module tb_bpred_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid, pred_taken, pred_ready;
  logic [31:0] pred_target, pred_fallthru;
  logic        res_valid, res_taken;
  logic [31:0] res_target;
  logic        upd_valid, upd_taken, flush, redirect_valid, res_err;
  logic [31:0] redirect_pc;
  logic [2:0]  inflight;
  logic [15:0] branch_cnt, mispred_cnt;

  logic        s_pred_valid, s_pred_taken, s_pred_ready;
  logic [31:0] s_pred_target, s_pred_fallthru;
  logic        s_res_valid, s_res_taken;
  logic [31:0] s_res_target;
  logic        s_upd_valid, s_upd_taken, s_flush, s_redirect_valid, s_res_err;
  logic [31:0] s_redirect_pc;
  logic [1:0]  s_inflight;
  logic [3:0]  s_branch_cnt, s_mispred_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bpred_resolve_ctrl dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_fallthru(pred_fallthru), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inflight(inflight),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt), .res_err(res_err)
  );

  bpred_resolve_ctrl #(.DEPTH(2), .PC_W(32), .FLUSH_CYCLES(1), .CNT_W(4)) sat_dut (
    .clk(clk), .rst(rst),
    .pred_valid(s_pred_valid), .pred_taken(s_pred_taken), .pred_target(s_pred_target),
    .pred_fallthru(s_pred_fallthru), .pred_ready(s_pred_ready),
    .res_valid(s_res_valid), .res_taken(s_res_taken), .res_target(s_res_target),
    .upd_valid(s_upd_valid), .upd_taken(s_upd_taken), .flush(s_flush),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .inflight(s_inflight),
    .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt), .res_err(s_res_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic tk(input int i);
    return (i % 3) != 1;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    pred_valid = 0; pred_taken = 0; pred_target = 0; pred_fallthru = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
    s_pred_valid = 0; s_pred_taken = 0; s_pred_target = 0; s_pred_fallthru = 0;
    s_res_valid = 0; s_res_taken = 0; s_res_target = 0;
    #3;
    checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", pred_ready); end
    checks++; if ({upd_valid, upd_taken, flush, redirect_valid, res_err} !== 5'b0) begin
      errors++; $display("FAIL rst_flags got %b want 00000", {upd_valid, upd_taken, flush, redirect_valid, res_err}); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL rst_inflight got %0d want 0", inflight); end
    checks++; if ({branch_cnt, mispred_cnt} !== 32'h0) begin
      errors++; $display("FAIL rst_cnt got %h want 0", {branch_cnt, mispred_cnt}); end
    cyc(); cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      pred_valid = 1; pred_taken = 1;
      pred_target = 32'h100 + 32'(i) * 32'h10; pred_fallthru = 32'h1000 + 32'(i) * 4;
      checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %b want 1", i, pred_ready); end
      cyc();
    end
    pred_target = 32'h999;
    checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL fill_inflight got %0d want 4", inflight); end
    checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", pred_ready); end
    cyc();
    pred_valid = 0;
    checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL full_ignore got %0d want 4", inflight); end
  endtask

  task automatic test_resolve_ok();
    for (int i = 0; i < 4; i++) begin
      res_valid = 1; res_taken = 1; res_target = 32'h100 + 32'(i) * 32'h10;
      cyc();
      checks++; if ({upd_valid, upd_taken, flush, redirect_valid} !== 4'b1100) begin
        errors++; $display("FAIL ok_upd%0d got %b want 1100", i, {upd_valid, upd_taken, flush, redirect_valid}); end
    end
    res_valid = 0;
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL ok_inflight got %0d want 0", inflight); end
    checks++; if (branch_cnt !== 16'd4 || mispred_cnt !== 16'd0) begin
      errors++; $display("FAIL ok_cnt got %0d/%0d want 4/0", branch_cnt, mispred_cnt); end
    cyc();
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL ok_upd_end got %b want 0", upd_valid); end
  endtask

  task automatic test_mispred_dir();
    pred_valid = 1; pred_taken = 1; pred_target = 32'h200; pred_fallthru = 32'h44;
    cyc();
    pred_valid = 0; res_valid = 1; res_taken = 0; res_target = 32'h200;
    cyc();
    res_valid = 0;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h44) begin
      errors++; $display("FAIL dir_redir got %b/%h want 1/00000044", redirect_valid, redirect_pc); end
    checks++; if ({upd_valid, upd_taken, flush, pred_ready} !== 4'b1010) begin
      errors++; $display("FAIL dir_n1 got %b want 1010", {upd_valid, upd_taken, flush, pred_ready}); end
    checks++; if (mispred_cnt !== 16'd1 || inflight !== 3'd0) begin
      errors++; $display("FAIL dir_cnt got %0d/%0d want 1/0", mispred_cnt, inflight); end
    cyc();
    checks++; if ({redirect_valid, flush, pred_ready} !== 3'b010) begin
      errors++; $display("FAIL dir_n2 got %b want 010", {redirect_valid, flush, pred_ready}); end
    cyc();
    checks++; if ({flush, pred_ready} !== 2'b01) begin
      errors++; $display("FAIL dir_n3 got %b want 01", {flush, pred_ready}); end
  endtask

  task automatic test_mispred_target();
    for (int i = 0; i < 3; i++) begin
      pred_valid = 1; pred_taken = 1;
      pred_target = 32'h280 + 32'(i) * 32'h10; pred_fallthru = 32'h60 + 32'(i) * 4;
      cyc();
    end
    pred_target = 32'h2b0;
    res_valid = 1; res_taken = 1; res_target = 32'h300;
    cyc();
    pred_valid = 0; res_valid = 0;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin
      errors++; $display("FAIL tgt_redir got %b/%h want 1/00000300", redirect_valid, redirect_pc); end
    checks++; if (inflight !== 3'd0 || flush !== 1'b1) begin
      errors++; $display("FAIL tgt_clear got %0d/%b want 0/1", inflight, flush); end
    cyc(); cyc();
    checks++; if (mispred_cnt !== 16'd2 || branch_cnt !== 16'd6 || pred_ready !== 1'b1) begin
      errors++; $display("FAIL tgt_cnt got %0d/%0d/%b want 2/6/1", mispred_cnt, branch_cnt, pred_ready); end
  endtask

  task automatic test_back_to_back();
    pred_valid = 1; pred_taken = tk(0); pred_target = 32'h400; pred_fallthru = 32'h800;
    cyc();
    for (int k = 0; k < 10; k++) begin
      pred_valid = 1; pred_taken = tk(k + 1);
      pred_target = 32'h400 + 32'(k + 1) * 4; pred_fallthru = 32'h800 + 32'(k + 1) * 4;
      res_valid = 1; res_taken = tk(k);
      res_target = tk(k) ? 32'h400 + 32'(k) * 4 : 32'hdead;
      cyc();
      checks++; if ({upd_valid, upd_taken, redirect_valid} !== {1'b1, tk(k), 1'b0} || inflight !== 3'd1) begin
        errors++; $display("FAIL b2b_%0d got %b inflight %0d want %b inflight 1",
                           k, {upd_valid, upd_taken, redirect_valid}, inflight, {1'b1, tk(k), 1'b0}); end
    end
    pred_valid = 0; res_valid = 1; res_taken = tk(10); res_target = 32'h400 + 32'd40;
    cyc();
    res_valid = 0;
    checks++; if ({upd_valid, upd_taken, redirect_valid} !== {1'b1, tk(10), 1'b0} || inflight !== 3'd0) begin
      errors++; $display("FAIL b2b_last got %b inflight %0d", {upd_valid, upd_taken, redirect_valid}, inflight); end
    checks++; if (branch_cnt !== 16'd17) begin errors++; $display("FAIL b2b_cnt got %0d want 17", branch_cnt); end
  endtask

  task automatic test_empty_resolve();
    res_valid = 1; res_taken = 1; res_target = 32'h10;
    cyc();
    res_valid = 0;
    checks++; if (upd_valid !== 1'b0 || res_err !== 1'b1) begin
      errors++; $display("FAIL empty got upd %b err %b want 0/1", upd_valid, res_err); end
    cyc();
    checks++; if (res_err !== 1'b1 || branch_cnt !== 16'd17) begin
      errors++; $display("FAIL empty_hold got err %b cnt %0d want 1/17", res_err, branch_cnt); end
  endtask

  task automatic test_reset_midflush();
    pred_valid = 1; pred_taken = 0; pred_target = 32'h500; pred_fallthru = 32'h504;
    cyc();
    pred_valid = 0; res_valid = 1; res_taken = 1; res_target = 32'h600;
    cyc();
    res_valid = 0;
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h600) begin
      errors++; $display("FAIL mid_pre got %b/%h want 1/00000600", flush, redirect_pc); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({flush, pred_ready, redirect_valid, upd_valid, res_err} !== 5'b01000) begin
      errors++; $display("FAIL mid_rst got %b want 01000", {flush, pred_ready, redirect_valid, upd_valid, res_err}); end
    checks++; if (inflight !== 3'd0 || branch_cnt !== 16'd0 || mispred_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_rst_cnt got %0d/%0d/%0d want 0", inflight, branch_cnt, mispred_cnt); end
    cyc();
    rst = 1'b1;
    cyc();
    checks++; if (redirect_valid !== 1'b0 || pred_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rel got %b/%b want 0/1", redirect_valid, pred_ready); end
  endtask

  task automatic test_saturation();
    s_pred_valid = 1; s_pred_taken = 1; s_pred_target = 32'h10; s_pred_fallthru = 32'h4;
    s_res_taken = 1; s_res_target = 32'h10;
    cyc();
    for (int k = 0; k < 20; k++) begin
      s_res_valid = 1;
      cyc();
      if (k == 13) begin
        checks++; if (s_branch_cnt !== 4'd14) begin errors++; $display("FAIL sat_pre got %0d want 14", s_branch_cnt); end
      end
    end
    s_pred_valid = 0;
    cyc();
    s_res_valid = 0;
    checks++; if (s_branch_cnt !== 4'hf || s_inflight !== 2'd0) begin
      errors++; $display("FAIL sat_branch got %h/%0d want f/0", s_branch_cnt, s_inflight); end
    for (int k = 0; k < 17; k++) begin
      s_pred_valid = 1;
      cyc();
      s_pred_valid = 0; s_res_valid = 1; s_res_taken = 0;
      cyc();
      s_res_valid = 0;
      cyc();
    end
    checks++; if (s_mispred_cnt !== 4'hf || s_branch_cnt !== 4'hf) begin
      errors++; $display("FAIL sat_mis got %h/%h want f/f", s_mispred_cnt, s_branch_cnt); end
    checks++; if (s_pred_ready !== 1'b1 || s_flush !== 1'b0) begin
      errors++; $display("FAIL sat_end got %b/%b want 1/0", s_pred_ready, s_flush); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_resolve_ok();
    test_mispred_dir();
    test_mispred_target();
    test_back_to_back();
    test_empty_resolve();
    test_reset_midflush();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
